// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32 data memory with sized loads/stores, valid/ready request,
// one-cycle response pulse and a configurable number of wait states.
module data_mem_lsu #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_misaligned,
  output logic                  rsp_illegal
);

  localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 32'd0) ? 4'(WAIT_STATES - 32'd1) : 4'd0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    logic ill;
    case (f3)
      3'b000, 3'b001, 3'b010: ill = 1'b0;
      3'b100, 3'b101:         ill = store;
      default:                ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lane[0];
      2'b10:   mis = (lane != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Little-endian lane select followed by sign/zero extension
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      3'b010:  r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [31:0]           mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  cap_store_q, cap_store_d;
  logic [2:0]            cap_f3_q, cap_f3_d;
  logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
  logic [31:0]           cap_wdata_q, cap_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_mis_q, rsp_mis_d;
  logic                  rsp_ill_q, rsp_ill_d;

  logic                  accept_s;
  logic                  enter_resp_s;
  logic                  acc_store_s;
  logic [2:0]            acc_f3_s;
  logic [ADDR_WIDTH-1:0] acc_addr_s;
  logic [31:0]           acc_wdata_s;
  logic [ADDR_WIDTH-3:0] acc_idx_s;
  logic [1:0]            acc_lane_s;
  logic                  acc_ill_s;
  logic                  acc_mis_s;
  logic                  wr_en_s;
  logic [3:0]            wr_be_s;
  logic [31:0]           wr_data_s;
  logic [31:0]           rd_word_s;

  assign accept_s = req_valid && ready_q && (state_q == ST_IDLE);

  // With no wait states the access happens on the accept edge, so live inputs are used there
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_store_s = req_store;
      acc_f3_s    = req_funct3;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
    end else begin
      acc_store_s = cap_store_q;
      acc_f3_s    = cap_f3_q;
      acc_addr_s  = cap_addr_q;
      acc_wdata_s = cap_wdata_q;
    end
  end

  assign acc_idx_s  = acc_addr_s[ADDR_WIDTH-1:2];
  assign acc_lane_s = acc_addr_s[1:0];
  assign acc_ill_s  = f3_illegal(acc_store_s, acc_f3_s);
  assign acc_mis_s  = !acc_ill_s && f3_misaligned(acc_f3_s, acc_lane_s);
  assign rd_word_s  = mem[acc_idx_s];
  assign wr_be_s    = store_be(acc_f3_s, acc_lane_s);
  assign wr_data_s  = store_data(acc_f3_s, acc_wdata_s);

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (WAIT_STATES > 32'd0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_resp_s = (state_d == ST_RESP);
  assign wr_en_s      = enter_resp_s && !rst && acc_store_s && !acc_ill_s && !acc_mis_s;
  assign ready_d      = (state_d == ST_IDLE);

  // Request capture and registered response fields
  always_comb begin
    cap_store_d = cap_store_q;
    cap_f3_d    = cap_f3_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    if (accept_s) begin
      cap_store_d = req_store;
      cap_f3_d    = req_funct3;
      cap_addr_d  = req_addr;
      cap_wdata_d = req_wdata;
    end else begin
      cap_store_d = cap_store_q;
    end
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_mis_d   = 1'b0;
    rsp_ill_d   = 1'b0;
    if (enter_resp_s) begin
      rsp_valid_d = 1'b1;
      rsp_ill_d   = acc_ill_s;
      rsp_mis_d   = acc_mis_s;
      if (acc_store_s || acc_ill_s || acc_mis_s) begin
        rsp_rdata_d = 32'd0;
      end else begin
        rsp_rdata_d = load_extract(acc_f3_s, acc_lane_s, rd_word_s);
      end
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  // Control and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b1;
      cap_store_q <= 1'b0;
      cap_f3_q    <= 3'd0;
      cap_addr_q  <= '0;
      cap_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_mis_q   <= 1'b0;
      rsp_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      cap_store_q <= cap_store_d;
      cap_f3_q    <= cap_f3_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_ill_q   <= rsp_ill_d;
    end
  end

  // Byte-lane writes; storage is intentionally not reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en_s && wr_be_s[b]) begin
        mem[acc_idx_s][b*8 +: 8] <= wr_data_s[b*8 +: 8];
      end
    end
  end

  assign req_ready      = ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_misaligned = rsp_mis_q;
  assign rsp_illegal    = rsp_ill_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench: one instance with no wait states, one with three.
module tb_data_mem_lsu;

  localparam int WS0 = 0;
  localparam int WS3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       valid_s;
  logic [1:0]       ready_s;
  logic [1:0]       store_s;
  logic [1:0][2:0]  f3_s;
  logic [1:0][11:0] addr_s;
  logic [1:0][31:0] wdata_s;
  logic [1:0]       rvalid_s;
  logic [1:0][31:0] rdata_s;
  logic [1:0]       mis_s;
  logic [1:0]       ill_s;

  int total = 0;
  int bad   = 0;

  data_mem_lsu #(.ADDR_WIDTH(12), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(valid_s[0]), .req_ready(ready_s[0]),
    .req_store(store_s[0]), .req_funct3(f3_s[0]), .req_addr(addr_s[0]),
    .req_wdata(wdata_s[0]), .rsp_valid(rvalid_s[0]), .rsp_rdata(rdata_s[0]),
    .rsp_misaligned(mis_s[0]), .rsp_illegal(ill_s[0])
  );

  data_mem_lsu #(.ADDR_WIDTH(12), .WAIT_STATES(WS3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(valid_s[1]), .req_ready(ready_s[1]),
    .req_store(store_s[1]), .req_funct3(f3_s[1]), .req_addr(addr_s[1]),
    .req_wdata(wdata_s[1]), .rsp_valid(rvalid_s[1]), .rsp_rdata(rdata_s[1]),
    .rsp_misaligned(mis_s[1]), .rsp_illegal(ill_s[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One full transaction on instance d; scr scrambles the request inputs while busy
  task automatic txn(input string tag, input int d, input logic st, input logic [2:0] f3,
                     input logic [11:0] a, input logic [31:0] wd, input bit scr,
                     input logic [31:0] exp_rd, input logic exp_mis, input logic exp_ill);
    int lat;
    int ws;
    logic [31:0] rd;
    logic mis;
    logic ill;
    ws = (d == 0) ? WS0 : WS3;
    lat = 0; rd = 32'd0; mis = 1'b0; ill = 1'b0;
    @(negedge clk);
    chk({tag, ".ready_idle"}, {31'd0, ready_s[d]}, 32'd1);
    valid_s[d] = 1'b1; store_s[d] = st; f3_s[d] = f3; addr_s[d] = a; wdata_s[d] = wd;
    @(posedge clk);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      valid_s[d] = scr;
      if (scr) begin
        addr_s[d] = 12'hFFC; wdata_s[d] = 32'hDEADBEEF; f3_s[d] = 3'b011; store_s[d] = ~st;
      end
      chk({tag, ".ready_busy"}, {31'd0, ready_s[d]}, 32'd0);
      if (rvalid_s[d]) begin
        lat = k; rd = rdata_s[d]; mis = mis_s[d]; ill = ill_s[d];
      end
    end
    valid_s[d] = 1'b0;
    chk({tag, ".latency"}, lat, ws + 1);
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".flags"}, {30'd0, mis, ill}, {30'd0, exp_mis, exp_ill});
    @(negedge clk);
    chk({tag, ".after"}, {28'd0, rvalid_s[d], mis_s[d], ill_s[d], ready_s[d]}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, ".ctl"}, {28'd0, ready_s[d], rvalid_s[d], mis_s[d], ill_s[d]}, 32'h8);
      chk({tag, ".rdata"}, rdata_s[d], 32'd0);
    end
  endtask

  initial begin
    bit seen;
    valid_s = '0; store_s = '0; f3_s = '0; addr_s = '0; wdata_s = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset0");

    txn("sw014",   0, 1'b1, 3'b010, 12'h014, 32'hABCDEF01, 1'b0, 32'h0,        1'b0, 1'b0);
    txn("lw014",   0, 1'b0, 3'b010, 12'h014, 32'h0,        1'b0, 32'hABCDEF01, 1'b0, 1'b0);
    txn("sw020",   0, 1'b1, 3'b010, 12'h020, 32'h00000000, 1'b0, 32'h0,        1'b0, 1'b0);
    txn("sb023",   0, 1'b1, 3'b000, 12'h023, 32'hFFFFFF80, 1'b0, 32'h0,        1'b0, 1'b0);
    txn("sh020",   0, 1'b1, 3'b001, 12'h020, 32'hAAAA1234, 1'b0, 32'h0,        1'b0, 1'b0);
    txn("lw020",   0, 1'b0, 3'b010, 12'h020, 32'h0,        1'b0, 32'h80001234, 1'b0, 1'b0);
    txn("lb023",   0, 1'b0, 3'b000, 12'h023, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0, 1'b0);
    txn("lbu023",  0, 1'b0, 3'b100, 12'h023, 32'h0,        1'b0, 32'h00000080, 1'b0, 1'b0);
    txn("lh020",   0, 1'b0, 3'b001, 12'h020, 32'h0,        1'b0, 32'h00001234, 1'b0, 1'b0);
    txn("sh032",   0, 1'b1, 3'b001, 12'h032, 32'h0000F00D, 1'b0, 32'h0,        1'b0, 1'b0);
    txn("lh032",   0, 1'b0, 3'b001, 12'h032, 32'h0,        1'b0, 32'hFFFFF00D, 1'b0, 1'b0);
    txn("lhu032",  0, 1'b0, 3'b101, 12'h032, 32'h0,        1'b0, 32'h0000F00D, 1'b0, 1'b0);
    txn("sw040",   0, 1'b1, 3'b010, 12'h040, 32'h55667788, 1'b0, 32'h0,        1'b0, 1'b0);
    txn("sw041m",  0, 1'b1, 3'b010, 12'h041, 32'h99999999, 1'b0, 32'h0,        1'b1, 1'b0);
    txn("lw040a",  0, 1'b0, 3'b010, 12'h040, 32'h0,        1'b0, 32'h55667788, 1'b0, 1'b0);
    txn("lh043m",  0, 1'b0, 3'b001, 12'h043, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0);
    txn("ld011i",  0, 1'b0, 3'b011, 12'h040, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1);
    txn("st100i",  0, 1'b1, 3'b100, 12'h040, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 1'b1);
    txn("st110i",  0, 1'b1, 3'b110, 12'h041, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 1'b1);
    txn("lw040b",  0, 1'b0, 3'b010, 12'h040, 32'h0,        1'b0, 32'h55667788, 1'b0, 1'b0);

    txn("w3sw050", 1, 1'b1, 3'b010, 12'h050, 32'h11111111, 1'b0, 32'h0,        1'b0, 1'b0);
    txn("w3lw050", 1, 1'b0, 3'b010, 12'h050, 32'h0,        1'b1, 32'h11111111, 1'b0, 1'b0);
    txn("w3sw060", 1, 1'b1, 3'b010, 12'h060, 32'h0BADF00D, 1'b1, 32'h0,        1'b0, 1'b0);
    txn("w3lw060", 1, 1'b0, 3'b010, 12'h060, 32'h0,        1'b0, 32'h0BADF00D, 1'b0, 1'b0);
    txn("w3lwffc", 1, 1'b0, 3'b010, 12'h060, 32'h0,        1'b0, 32'h0BADF00D, 1'b0, 1'b0);

    // Reset while the three-wait-state instance is in WAIT for a store
    @(negedge clk);
    valid_s[1] = 1'b1; store_s[1] = 1'b1; f3_s[1] = 3'b010;
    addr_s[1] = 12'h050; wdata_s[1] = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    valid_s[1] = 1'b0;
    chk("rst.in_wait", {31'd0, ready_s[1]}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset1");
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid_s[1]) seen = 1'b1;
    end
    chk("rst.no_rsp", {31'd0, seen}, 32'd0);
    txn("rst.lw050", 1, 1'b0, 3'b010, 12'h050, 32'h0, 1'b0, 32'h11111111, 1'b0, 1'b0);
    txn("rst.lw014", 0, 1'b0, 3'b010, 12'h014, 32'h0, 1'b0, 32'hABCDEF01, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
